// File: rtl/regression_sample_loader_if.sv
// Sample stream and batch-presentation bundle for the regression sample loader.
// The loader sits on the slave side; the sample source / regression stage
// (or a bench standing in for both) sits on the master side.
interface regression_sample_loader_if #(
  parameter int N_SAMPLES = 20,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] in_y;
  logic              in_last;
  logic              batch_valid;
  logic              batch_ack;
  logic [DATA_W-1:0] X [0:N_SAMPLES-1];
  logic [DATA_W-1:0] Y [0:N_SAMPLES-1];
  logic [CNT_W-1:0]  count;
  logic              frame_err;

  modport master (
    output clear, in_valid, in_x, in_y, in_last, batch_ack,
    input  in_ready, batch_valid, X, Y, count, frame_err
  );

  modport slave (
    input  clear, in_valid, in_x, in_y, in_last, batch_ack,
    output in_ready, batch_valid, X, Y, count, frame_err
  );
endinterface

// File: rtl/regression_sample_loader.sv
// Collects N_SAMPLES (x, y) pairs from a valid/ready stream and presents them
// as parallel arrays, held stable until the regression stage acknowledges.
// An early in_last aborts the partial batch and raises a sticky frame error.
module regression_sample_loader #(
  parameter int N_SAMPLES = 20,
  parameter int DATA_W    = 32,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input logic                      clk,
  input logic                      rst,
  regression_sample_loader_if.slave bus
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N_SAMPLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;
  logic              wr_en;
  logic [DATA_W-1:0] x_q [0:N_SAMPLES-1];
  logic [DATA_W-1:0] y_q [0:N_SAMPLES-1];

  // State, sample counter and sticky frame error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Next state: clear overrides everything, including a same-cycle accept.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    if (bus.clear) begin
      state_d = FILL;
      count_d = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (bus.in_valid) begin
            wr_en = 1'b1;
            if (count_q == LAST_IDX) begin
              // in_last is legal either way on the final sample
              state_d = HOLD;
              count_d = FULL_CNT;
            end else if (bus.in_last) begin
              // sample is still written, but the partial batch is dropped
              count_d = '0;
              err_d   = 1'b1;
            end else begin
              count_d = count_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.batch_ack) begin
            state_d = FILL;
            count_d = '0;
          end
        end
        default: begin
          state_d = FILL;
          count_d = '0;
        end
      endcase
    end
  end

  // Sample storage; entries are only ever overwritten, never bulk-cleared
  // outside of reset, so stale data remains until the slot is refilled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else if (wr_en) begin
      x_q[count_q] <= bus.in_x;
      y_q[count_q] <= bus.in_y;
    end
  end

  // Handshake flags come straight from the state register.
  assign bus.in_ready    = (state_q == FILL);
  assign bus.batch_valid = (state_q == HOLD);
  assign bus.count       = count_q;
  assign bus.frame_err   = err_q;
  assign bus.X           = x_q;
  assign bus.Y           = y_q;

endmodule

// File: tb/tb_regression_sample_loader.sv
// Bench for regression_sample_loader: a reference model tracks state, count and
// frame error; accepted samples go into a scoreboard queue and are popped and
// compared against X/Y when a batch is presented.
module tb_regression_sample_loader;
  localparam int N      = 20;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(N + 1);

  logic clk;
  logic rst;

  regression_sample_loader_if #(.N_SAMPLES(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  regression_sample_loader #(.N_SAMPLES(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model
  bit                m_fill;
  int                m_cnt;
  bit                m_err;
  logic [DATA_W-1:0] mx [0:N-1];
  logic [DATA_W-1:0] my [0:N-1];
  logic [2*DATA_W-1:0] sb_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_fill = 1'b1;
    m_cnt  = 0;
    m_err  = 1'b0;
    sb_q.delete();
    for (int i = 0; i < N; i++) begin
      mx[i] = '0;
      my[i] = '0;
    end
  endtask

  task automatic check_ctrl(input string tag);
    chk({tag, ".in_ready"},    64'(bus.in_ready),    64'(m_fill));
    chk({tag, ".batch_valid"}, 64'(bus.batch_valid), 64'(!m_fill));
    chk({tag, ".count"},       64'(bus.count),       64'(m_cnt));
    chk({tag, ".frame_err"},   64'(bus.frame_err),   64'(m_err));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".in_ready"},    64'(bus.in_ready),    64'd1);
    chk({tag, ".batch_valid"}, 64'(bus.batch_valid), 64'd0);
    chk({tag, ".count"},       64'(bus.count),       64'd0);
    chk({tag, ".frame_err"},   64'(bus.frame_err),   64'd0);
    chk({tag, ".X0"},          64'(bus.X[0]),        64'd0);
    chk({tag, ".Y19"},         64'(bus.Y[N-1]),      64'd0);
  endtask

  // Advance one clock with the currently driven inputs, updating the model.
  task automatic cycle(input string tag);
    logic [2*DATA_W-1:0] e;
    bit was_fill;
    was_fill = m_fill;
    if (bus.clear) begin
      m_fill = 1'b1;
      m_cnt  = 0;
      m_err  = 1'b0;
      sb_q.delete();
    end else if (m_fill) begin
      if (bus.in_valid) begin
        mx[m_cnt] = bus.in_x;
        my[m_cnt] = bus.in_y;
        sb_q.push_back({bus.in_x, bus.in_y});
        if (m_cnt == N - 1) begin
          m_fill = 1'b0;
          m_cnt  = N;
        end else if (bus.in_last) begin
          m_cnt = 0;
          m_err = 1'b1;
          sb_q.delete();
        end else begin
          m_cnt++;
        end
      end
    end else if (bus.batch_ack) begin
      m_fill = 1'b1;
      m_cnt  = 0;
    end
    @(posedge clk);
    #1;
    check_ctrl(tag);
    if (was_fill && !m_fill) begin
      chk({tag, ".sb_depth"}, 64'(sb_q.size()), 64'(N));
      for (int i = 0; i < N && sb_q.size() > 0; i++) begin
        e = sb_q.pop_front();
        chk($sformatf("%s.X[%0d]", tag, i), 64'(bus.X[i]), 64'(e[2*DATA_W-1:DATA_W]));
        chk($sformatf("%s.Y[%0d]", tag, i), 64'(bus.Y[i]), 64'(e[DATA_W-1:0]));
      end
    end
  endtask

  task automatic idle_inputs();
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_last   = 1'b0;
    bus.batch_ack = 1'b0;
  endtask

  task automatic stream(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = $urandom;
      bus.in_y     = $urandom;
      bus.in_last  = 1'b0;
      cycle(tag);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic ack(input string tag);
    bus.in_valid  = 1'b0;
    bus.batch_ack = 1'b1;
    cycle(tag);
    bus.batch_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // back-to-back fill with known data
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = DATA_W'(i + 1);
      bus.in_y     = DATA_W'(2 * i + 3);
      cycle("b2b");
    end
    chk("b2b.X0",  64'(bus.X[0]),   64'd1);
    chk("b2b.X19", 64'(bus.X[N-1]), 64'd20);
    chk("b2b.Y19", 64'(bus.Y[N-1]), 64'd41);
    chk("b2b.count", 64'(bus.count), 64'd20);

    // hold with valid and new data offered
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = DATA_W'(100 + i);
      bus.in_y     = DATA_W'(200 + i);
      cycle("hold");
    end
    for (int i = 0; i < N; i++) begin
      chk($sformatf("hold.X[%0d]", i), 64'(bus.X[i]), 64'(i + 1));
      chk($sformatf("hold.Y[%0d]", i), 64'(bus.Y[i]), 64'(2 * i + 3));
    end
    ack("ack1");

    // ack while filling is ignored
    bus.batch_ack = 1'b1;
    cycle("fill_ack");
    bus.batch_ack = 1'b0;

    // valid toggling every other cycle
    for (int c = 0; c < 100 && m_fill; c++) begin
      bus.in_valid = c[0];
      bus.in_x     = $urandom;
      bus.in_y     = $urandom;
      cycle("toggle");
    end
    chk("toggle.done", 64'(bus.batch_valid), 64'd1);
    ack("ack2");

    // early last on index 6
    for (int k = 0; k < 7; k++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = $urandom;
      bus.in_y     = $urandom;
      bus.in_last  = (k == 6);
      cycle("early");
    end
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b0;
    chk("early.frame_err", 64'(bus.frame_err), 64'd1);
    chk("early.count",     64'(bus.count),     64'd0);
    chk("early.bv",        64'(bus.batch_valid), 64'd0);

    // full batch afterward, with in_last on the final sample
    stream(N - 1, "after_err");
    bus.in_valid = 1'b1;
    bus.in_x     = 32'h0BAD_F00D;
    bus.in_y     = 32'h1234_5678;
    bus.in_last  = 1'b1;
    cycle("after_err");
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk("after_err.bv",        64'(bus.batch_valid), 64'd1);
    chk("after_err.frame_err", 64'(bus.frame_err),   64'd1);
    ack("ack3");

    bus.clear = 1'b1;
    cycle("clear");
    bus.clear = 1'b0;
    chk("clear.frame_err", 64'(bus.frame_err), 64'd0);

    // clear coincident with the 20th accept
    stream(N - 1, "clr20");
    bus.in_valid = 1'b1;
    bus.in_x     = 32'hDEAD_BEEF;
    bus.in_y     = 32'hCAFE_0001;
    bus.clear    = 1'b1;
    cycle("clr20");
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr20.bv",    64'(bus.batch_valid), 64'd0);
    chk("clr20.ready", 64'(bus.in_ready),    64'd1);
    chk("clr20.count", 64'(bus.count),       64'd0);
    chk("clr20.X19",   64'(bus.X[N-1]),      64'h0BAD_F00D);
    chk("clr20.Y19",   64'(bus.Y[N-1]),      64'h1234_5678);

    // async reset mid-fill (count 12), with frame error set beforehand
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    cycle("pre_rst");
    bus.in_last  = 1'b0;
    stream(12, "mid");
    chk("mid.count", 64'(bus.count), 64'd12);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_fill");
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // async reset during hold
    stream(N, "fill4");
    chk("fill4.bv", 64'(bus.batch_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_hold");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    cycle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regression_sample_loader.md
# regression_sample_loader

Streaming front-end for the linear-regression stage. Accepts (x, y) sample pairs one per cycle over a valid/ready handshake and assembles them into a complete batch of N_SAMPLES pairs. It then presents the batch as parallel arrays X[0:N-1] and Y[0:N-1], held stable, until the downstream regression stage acknowledges it. It enforces framing with an optional last marker and a synchronous clear.

## Interface
- N_SAMPLES, 20: samples per batch; must match the regression stage's divisor.
- DATA_W, 32: width of each x and y sample.
- CNT_W, $clog2(N_SAMPLES+1): width of the sample counter.

- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort; discards any partial batch and clears frame_err.
- in_valid  input  1  sample pair on in_x/in_y is valid.
- in_ready  output  1  loader can accept a sample this cycle.
- in_x  input  DATA_W  x sample.
- in_y  input  DATA_W  y sample.
- in_last  input  1  optional marker: this sample is the last of its batch.
- batch_valid  output  1  X/Y hold a complete batch.
- batch_ack  input  1  downstream has consumed the batch.
- X  output  DATA_W x [0:N_SAMPLES-1]  x samples, index = arrival order.
- Y  output  DATA_W x [0:N_SAMPLES-1]  y samples, index = arrival order.
- count  output  CNT_W  samples accepted into the current batch.
- frame_err  output  1  sticky: in_last was seen before sample N_SAMPLES-1.

## Operation
- States: FILL and HOLD.
- FILL:
  - in_ready=1, batch_valid=0.
  - A transfer (accept) occurs when in_valid && in_ready.
  - On each accept: X[count] <= in_x, Y[count] <= in_y, count <= count+1.
- On the accept of the sample at index N_SAMPLES-1:
  - State moves to HOLD and count becomes N_SAMPLES.
  - in_last may be 1 or 0 on this sample; both are legal.
- Early last: an accept with in_last=1 at index k < N_SAMPLES-1:
  - The sample is written to X[k]/Y[k], but the batch is discarded.
  - count <= 0, frame_err <= 1, state stays FILL.
- HOLD:
  - in_ready=0, batch_valid=1.
  - X, Y and count are frozen.
  - On batch_ack=1: state moves to FILL and count <= 0.
- batch_ack while in FILL is ignored.
- X/Y are never bulk-cleared. Entries keep their last written value until overwritten. Downstream may use them only while batch_valid=1.
- clear=1, in either state:
  - Next state is FILL; count <= 0, batch_valid <= 0, frame_err <= 0.
  - Any same-cycle accept is suppressed: no array write, no count change.
  - X/Y contents are untouched.
- Priority: rst > clear > batch_ack/accept.
- frame_err stays set until clear or rst. Loading continues normally while it is set.
- Arithmetic: count is unsigned, never exceeds N_SAMPLES and never wraps. Sample data is stored verbatim with no arithmetic.

## Timing
- Reset values (asynchronous): state=FILL, in_ready=1, batch_valid=0, count=0, frame_err=0, all X[i]=0, all Y[i]=0.
- in_ready and batch_valid are decoded directly from state registers, with no combinational path from any input.
- Throughput is one sample per cycle while in FILL.
- Fill latency: with continuous in_valid, the Nth accept happens in cycle N-1 after entry to FILL. batch_valid is high from the following cycle.
- HOLD-to-FILL: the cycle after batch_ack, in_ready=1. The minimum gap between batches is one cycle with in_ready=0 after the ack cycle's edge.
- Accept and ack cannot coincide, because in_ready=0 in HOLD.
- clear takes effect at the next edge. A clear in the same cycle as the Nth accept leaves the loader in FILL with batch_valid=0.
- rst asserted mid-fill or mid-hold returns all outputs to reset values immediately, without waiting for clk.

## Test plan
- Reset, then stream 20 pairs back-to-back (x=i+1, y=2i+3) with in_valid held high:
  - in_ready falls and batch_valid rises in the cycle after the 20th accept.
  - X[0]=1, X[19]=20, Y[19]=41, count=20.
- Hold batch_ack=0 for 10 cycles with in_valid=1 and new data driven:
  - X/Y are unchanged, in_ready=0.
  - Pulse batch_ack: the next cycle has batch_valid=0, in_ready=1, count=0.
- Stream 20 samples with in_valid toggling every other cycle:
  - Exactly 20 accepts are recorded in order and the batch completes correctly.
- Assert in_last on the 7th sample (index 6):
  - frame_err=1, count=0, no batch_valid.
  - A following 20-sample stream completes a batch and frame_err stays 1.
  - Then assert clear: frame_err=0.
- Assert clear together with the 20th accept:
  - The next cycle has state FILL, count=0, batch_valid=0.
  - X[19] keeps its prior value.
- Assert rst asynchronously mid-fill (count=12) and again during HOLD:
  - All outputs reach their reset values before the next clk edge.
